// File: rtl/aes_subbytes_serial.sv
// rtl/aes_subbytes_serial.sv - iterative AES SubBytes over a 128-bit state using LANES S-boxes
//
// Purpose: takes one 128-bit AES state and rotates it through LANES S-box
// lanes, LANES bytes per cycle. After 16/LANES cycles the state is back in its
// original byte order with every byte substituted.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    input handshake, in_state sampled on the accept edge
//   in_state[127:0]      input state, byte 0 in bits [127:120]
//   out_valid/out_ready  output handshake, out_state frozen while out_valid
//   out_state[127:0]     substituted state, same byte order
//   busy                 high whenever a block is being processed or held

// aes_sbox - combinational AES S-box: GF(2^8) inverse followed by the affine map
// Ports: din[7:0] byte in, dout[7:0] substituted byte out
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;
  logic [7:0] sq;

  // Inverse as din^254 = din^2 * din^4 * ... * din^128; maps 0 to 0 as required.
  always_comb begin
    inv = 8'h01;
    sq  = din;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_subbytes_serial #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int N = 16 / LANES;
  localparam int W = 8 * LANES;
  localparam logic [3:0] CNT_LAST = 4'(N - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_subbytes_serial: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [127:0]  sreg;
  logic [W-1:0]  sub;
  logic [127:0]  rot;

  // Lane g substitutes the g-th byte from the top of sreg.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox u_sbox (
      .din  (sreg[127-8*g -: 8]),
      .dout (sub[W-1-8*g -: 8])
    );
  end

  // Rotate left by LANES bytes, substituted bytes re-entering at the bottom.
  if (LANES == 16) begin : g_rot_full
    assign rot = sub;
  end else begin : g_rot_part
    assign rot = {sreg[127-W:0], sub};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      sreg  <= 128'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sreg  <= in_state;
            cnt   <= 4'd0;
            state <= RUN;
          end
        end
        RUN: begin
          sreg <= rot;
          cnt  <= cnt + 4'd1;
          if (cnt == CNT_LAST) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_state = sreg;

endmodule

// File: tb/tb_aes_subbytes_serial.sv
// tb/tb_aes_subbytes_serial.sv - directed and streaming checks of aes_subbytes_serial for all LANES
module tb_aes_subbytes_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [4:0]   in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_state  [5];
  logic [127:0] out_state [5];

  // Instance g runs with LANES = 2^g.
  for (genvar g = 0; g < 5; g++) begin : g_dut
    aes_subbytes_serial #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
  end

  localparam logic [7:0] SBOX_T [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ORD_IN   = 128'h00010253_00000000_00000000_00000000;
  localparam logic [127:0] ORD_OUT  = 128'h637c77ed_63636363_63636363_63636363;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, need %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = SBOX_T[s[127-8*i -: 8]];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present st for one accept edge; returns one cycle after the accept edge.
  task automatic send(input int k, input logic [127:0] st, input string tag);
    int t;
    t = 0;
    while (!in_ready[k] && t < 50) begin
      tick();
      t++;
    end
    check({tag, "_in_ready"}, 128'(in_ready[k]), 128'd1);
    in_state[k] = st;
    in_valid[k] = 1'b1;
    tick();
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int exp_lat, input string tag);
    int lat;
    lat = 0;
    while (!out_valid[k] && lat < 64) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
  endtask

  task automatic take(input int k, input string tag);
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
    check({tag, "_ready_after"}, 128'(in_ready[k]), 128'd1);
    check({tag, "_valid_after"}, 128'(out_valid[k]), 128'd0);
  endtask

  task automatic run_vec(input int k, input logic [127:0] st, input logic [127:0] exp, input string tag);
    send(k, st, tag);
    wait_done(k, 16 >> k, tag);
    check({tag, "_data"}, out_state[k], exp);
    take(k, tag);
  endtask

  // Handshake-level stream; back_to_back holds both sides ready and checks spacing.
  task automatic stream(input int k, input int nblk, input bit back_to_back, input string tag);
    logic [127:0] q[$];
    logic [127:0] obs, stim;
    logic         acc, tk;
    int sent, got, cycles, last_acc;
    sent = 0; got = 0; cycles = 0; last_acc = -1;
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b0;
    while (got < nblk && cycles < 20000) begin
      if (sent < nblk && !in_valid[k] && (back_to_back || $urandom_range(0, 3) != 0)) begin
        in_valid[k] = 1'b1;
        in_state[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      out_ready[k] = back_to_back ? 1'b1 : ($urandom_range(0, 2) != 0);
      #1;
      acc  = in_valid[k] & in_ready[k];
      tk   = out_valid[k] & out_ready[k];
      obs  = out_state[k];
      stim = in_state[k];
      tick();
      cycles++;
      if (acc) begin
        q.push_back(ref_sub(stim));
        sent++;
        in_valid[k] = 1'b0;
        if (back_to_back && last_acc >= 0)
          check({tag, "_spacing"}, 128'(cycles - last_acc), 128'((16 >> k) + 2));
        last_acc = cycles;
      end
      if (tk) begin
        if (q.size() == 0) check({tag, "_extra_output"}, 128'd1, 128'd0);
        else check({tag, "_data"}, obs, q.pop_front());
        got++;
      end
    end
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b0;
    check({tag, "_count"}, 128'(got), 128'(nblk));
    check({tag, "_leftover"}, 128'(q.size()), 128'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, need completion");
    $fatal(1);
  end

  initial begin
    int cnt_v;
    rst = 1'b1;
    in_valid = '0;
    out_ready = '0;
    for (int k = 0; k < 5; k++) in_state[k] = '0;
    repeat (3) tick();
    check("rst_in_ready_held", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'h1f);
    for (int k = 0; k < 5; k++) check($sformatf("post_rst_out_state%0d", k), out_state[k], 128'd0);

    // FIPS-197 SubBytes vector on every lane count.
    for (int k = 0; k < 5; k++) run_vec(k, FIPS_IN, FIPS_OUT, $sformatf("fips_l%0d", 1 << k));

    run_vec(0, 128'd0, {16{8'h63}}, "zero_l1");
    run_vec(0, {16{8'hff}}, {16{8'h16}}, "ones_l1");
    run_vec(0, ORD_IN, ORD_OUT, "order_l1");
    run_vec(4, ORD_IN, ORD_OUT, "order_l16");
    run_vec(2, {16{8'hff}}, {16{8'h16}}, "ones_l4");

    // Back-pressure: DONE holds with stray in_valid pulses.
    send(0, ORD_IN, "bp");
    wait_done(0, 16, "bp");
    for (int c = 0; c < 20; c++) begin
      in_valid[0] = 1'($urandom_range(0, 1));
      in_state[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      check("bp_hold_data", out_state[0], ORD_OUT);
      check("bp_in_ready", 128'(in_ready[0]), 128'd0);
      check("bp_out_valid", 128'(out_valid[0]), 128'd1);
    end
    in_valid[0] = 1'b0;
    take(0, "bp");
    check("bp_busy_after", 128'(busy[0]), 128'd0);

    // Input isolation on LANES=2: changing in_state and pulsing in_valid in RUN.
    send(1, FIPS_IN, "iso");
    tick();
    in_state[1] = {16{8'ha5}};
    in_valid[1] = 1'b1;
    tick();
    tick();
    in_valid[1] = 1'b0;
    wait_done(1, 5, "iso");
    check("iso_data", out_state[1], FIPS_OUT);
    take(1, "iso");
    cnt_v = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid[1] || busy[1]) cnt_v++;
    end
    check("iso_single_output", 128'(cnt_v), 128'd0);

    // Reset while cnt = 7 on LANES=1 discards the block.
    send(0, FIPS_IN, "mid_rst");
    repeat (7) tick();
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready_low", 128'(in_ready[0]), 128'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 128'(busy[0]), 128'd0);
    check("mid_rst_in_ready", 128'(in_ready[0]), 128'd1);
    check("mid_rst_out_state", out_state[0], 128'd0);
    cnt_v = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (out_valid[0]) cnt_v++;
    end
    check("mid_rst_no_output", 128'(cnt_v), 128'd0);
    run_vec(0, FIPS_IN, FIPS_OUT, "after_rst");

    stream(0, 100, 1'b0, "stream_rand_l1");
    stream(0, 5, 1'b1, "b2b_l1");
    stream(4, 6, 1'b1, "b2b_l16");
    stream(2, 20, 1'b0, "stream_rand_l4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
